// File: rtl/d_bus_arb_pkg.sv
// d_bus_arb shared types and constants.
// Bus FSM states, master indices, default error word.
package d_bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WR_WAIT,
    RD_WAIT
  } state_t;

  localparam logic M_CORE = 1'b0;
  localparam logic M_DBG  = 1'b1;

  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

  function automatic logic oh2idx(input logic [1:0] oh);
    return oh[1];
  endfunction

endpackage

// File: rtl/d_bus_arb_rr_arb2.sv
// Two-input round-robin picker.
// On a tie, the master that was not served last wins.
module d_bus_arb_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // one-hot grant from request pair and last winner
  always_comb begin
    grant = 2'b00;
    unique case (1'b1)
      (req == 2'b11): grant = last_grant ? 2'b01 : 2'b10;
      (req == 2'b01): grant = 2'b01;
      (req == 2'b10): grant = 2'b10;
      default:        grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/d_bus_arb.sv
// Two-master data-bus arbiter in front of the data-memory mux.
// One outstanding transaction, read timeout with error return.
module d_bus_arb
  import d_bus_arb_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ADDR_LEN = 14,
  parameter int TIMEOUT  = 64,
  parameter logic [XLEN-1:0] ERR_DATA = XLEN'(ERR_DATA_DEF)
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic [1:0][ADDR_LEN-1:0] m_addr,
  input  logic [1:0]               m_rd_req,
  input  logic [1:0]               m_wr_req,
  input  logic [1:0][XLEN/8-1:0]   m_wr_be,
  input  logic [1:0][XLEN-1:0]     m_wr_data,
  output logic [1:0]               m_rd_ready,
  output logic [1:0]               m_wr_ready,
  output logic [XLEN-1:0]          m_rd_data,
  output logic                     m_rd_err,
  output logic [ADDR_LEN-1:0]      s_addr,
  output logic                     s_rd_req,
  output logic                     s_wr_req,
  output logic [XLEN/8-1:0]        s_wr_be,
  output logic [XLEN-1:0]          s_wr_data,
  input  logic                     s_rd_ready,
  input  logic                     s_wr_ready,
  input  logic [XLEN-1:0]          s_rd_data,
  output logic                     busy
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic                last_q, last_d;
  logic                owner_q, owner_d;
  logic [ADDR_LEN-1:0] addr_q, addr_d;
  logic [TW-1:0]       timer_q, timer_d;

  logic [1:0] req;
  logic [1:0] grant;
  logic       g;

  assign req = m_rd_req | m_wr_req;
  assign g   = oh2idx(grant);

  d_bus_arb_rr_arb2 u_rr (
    .req        (req),
    .last_grant (last_q),
    .grant      (grant)
  );

  // state and transaction context registers
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= IDLE;
      last_q  <= M_DBG;
      owner_q <= M_CORE;
      addr_q  <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      timer_q <= timer_d;
    end
  end

  // next state, bus drive and completion pulses
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    timer_d    = timer_q;
    m_rd_ready = 2'b00;
    m_wr_ready = 2'b00;
    m_rd_data  = '0;
    m_rd_err   = 1'b0;
    s_addr     = '0;
    s_rd_req   = 1'b0;
    s_wr_req   = 1'b0;
    s_wr_be    = '0;
    s_wr_data  = '0;
    unique case (state_q)
      IDLE: begin
        if (|grant) begin
          s_addr = m_addr[g];
          if (m_wr_req[g]) begin
            s_wr_req  = 1'b1;
            s_wr_be   = m_wr_be[g];
            s_wr_data = m_wr_data[g];
            if (s_wr_ready) begin
              m_wr_ready[g] = 1'b1;
              last_d        = g;
            end else begin
              owner_d = g;
              state_d = WR_WAIT;
            end
          end else begin
            s_rd_req = 1'b1;
            owner_d  = g;
            addr_d   = m_addr[g];
            timer_d  = '0;
            state_d  = RD_WAIT;
          end
        end
      end
      WR_WAIT: begin
        s_wr_req  = 1'b1;
        s_addr    = m_addr[owner_q];
        s_wr_be   = m_wr_be[owner_q];
        s_wr_data = m_wr_data[owner_q];
        if (s_wr_ready) begin
          m_wr_ready[owner_q] = 1'b1;
          last_d  = owner_q;
          state_d = IDLE;
        end
      end
      RD_WAIT: begin
        s_addr = addr_q;
        if (s_rd_ready) begin
          m_rd_ready[owner_q] = 1'b1;
          m_rd_data = s_rd_data;
          last_d    = owner_q;
          state_d   = IDLE;
        end else if (timer_q == T_LAST) begin
          m_rd_ready[owner_q] = 1'b1;
          m_rd_data = ERR_DATA;
          m_rd_err  = 1'b1;
          last_d    = owner_q;
          state_d   = IDLE;
        end else if (timer_q != '1) begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_d_bus_arb.sv
// Directed bench for d_bus_arb.
// Expected completions are queued; a monitor pops and compares.
module tb_d_bus_arb;

  logic              clk = 1'b0;
  logic              rstb;
  logic [1:0][13:0]  m_addr;
  logic [1:0]        m_rd_req;
  logic [1:0]        m_wr_req;
  logic [1:0][3:0]   m_wr_be;
  logic [1:0][31:0]  m_wr_data;
  logic [1:0]        m_rd_ready;
  logic [1:0]        m_wr_ready;
  logic [31:0]       m_rd_data;
  logic              m_rd_err;
  logic [13:0]       s_addr;
  logic              s_rd_req;
  logic              s_wr_req;
  logic [3:0]        s_wr_be;
  logic [31:0]       s_wr_data;
  logic              s_rd_ready;
  logic              s_wr_ready;
  logic [31:0]       s_rd_data;
  logic              busy;

  d_bus_arb dut (
    .clk        (clk),
    .rstb       (rstb),
    .m_addr     (m_addr),
    .m_rd_req   (m_rd_req),
    .m_wr_req   (m_wr_req),
    .m_wr_be    (m_wr_be),
    .m_wr_data  (m_wr_data),
    .m_rd_ready (m_rd_ready),
    .m_wr_ready (m_wr_ready),
    .m_rd_data  (m_rd_data),
    .m_rd_err   (m_rd_err),
    .s_addr     (s_addr),
    .s_rd_req   (s_rd_req),
    .s_wr_req   (s_wr_req),
    .s_wr_be    (s_wr_be),
    .s_wr_data  (s_wr_data),
    .s_rd_ready (s_rd_ready),
    .s_wr_ready (s_wr_ready),
    .s_rd_data  (s_rd_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rd;
    bit          m;
    logic [31:0] data;
    bit          err;
    int          cyc;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int srd_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic push(input bit rd, input bit m, input logic [31:0] d,
                      input bit er, input int c);
    exp_t x;
    x.rd = rd; x.m = m; x.data = d; x.err = er; x.cyc = c;
    q.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] outs();
    return {m_rd_ready, m_wr_ready, m_rd_data, m_rd_err, s_addr,
            s_rd_req, s_wr_req, s_wr_be, s_wr_data, busy};
  endfunction

  // response monitor: every completion pulse must match the queue head
  always @(negedge clk) begin
    if (s_rd_req) srd_cnt++;
    if (|{m_rd_ready, m_wr_ready}) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp rd=%b wr=%b cyc=%0d required=none",
                 m_rd_ready, m_wr_ready, cyc);
      end else begin
        e = q.pop_front();
        chk("rsp_onehot", $countones({m_rd_ready, m_wr_ready}), 1);
        chk("rsp_kind", |m_rd_ready, e.rd);
        chk("rsp_master", m_rd_ready[1] | m_wr_ready[1], e.m);
        chk("rsp_data", m_rd_data, e.data);
        chk("rsp_err", m_rd_err, e.err);
        chk("rsp_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic do_reset();
    rstb = 1'b0;
    m_addr = '0; m_rd_req = '0; m_wr_req = '0;
    m_wr_be = '0; m_wr_data = '0;
    s_rd_ready = 0; s_wr_ready = 0; s_rd_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", outs(), '0);
    step();
    rstb = 1'b1;
  endtask

  int n;
  int s0;
  logic [31:0] dv [4] = '{32'h1111_0000, 32'h2222_0001,
                          32'h3333_0002, 32'h4444_0003};

  initial begin
    do_reset();
    @(negedge clk);
    chk("idle_outs", outs(), '0);

    // single read, master 0, data next cycle
    step();
    m_addr[0] = 14'h2004; m_rd_req = 2'b01; n = cyc;
    push(1, 0, 32'h1234_5678, 0, n + 1);
    @(negedge clk);
    chk("t1_srd", s_rd_req, 1);
    chk("t1_saddr", s_addr, 14'h2004);
    step();
    m_addr[0] = 14'h0000;
    s_rd_ready = 1; s_rd_data = 32'h1234_5678;
    @(negedge clk);
    chk("t1_srd_low", s_rd_req, 0);
    chk("t1_saddr_hold", s_addr, 14'h2004);
    step();
    m_rd_req = 0; s_rd_ready = 0; s_rd_data = '0;
    @(negedge clk);
    chk("t1_idle", busy, 0);

    // simultaneous writes right after reset
    do_reset();
    m_addr[0] = 14'h0010; m_addr[1] = 14'h0020;
    m_wr_data[0] = 32'hAAAA_0000; m_wr_data[1] = 32'hBBBB_1111;
    m_wr_be[0] = 4'hF; m_wr_be[1] = 4'h3;
    m_wr_req = 2'b11; s_wr_ready = 1; n = cyc;
    push(0, 0, '0, 0, n);
    push(0, 1, '0, 0, n + 1);
    @(negedge clk);
    chk("t2_wd0", s_wr_data, 32'hAAAA_0000);
    chk("t2_wa0", s_addr, 14'h0010);
    chk("t2_be0", s_wr_be, 4'hF);
    step();
    m_wr_req = 2'b10;
    @(negedge clk);
    chk("t2_wd1", s_wr_data, 32'hBBBB_1111);
    chk("t2_wa1", s_addr, 14'h0020);
    chk("t2_be1", s_wr_be, 4'h3);
    step();
    m_wr_req = 0; s_wr_ready = 0;

    // back-to-back reads, both masters held high
    m_addr[0] = 14'h0100; m_addr[1] = 14'h0200;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      m_rd_req = 2'b11; s_rd_ready = 0;
      @(negedge clk);
      chk("t3_srd", s_rd_req, 1);
      chk("t3_saddr", s_addr, (i % 2) ? 14'h0200 : 14'h0100);
      step();
      s_rd_ready = 1; s_rd_data = dv[i];
      push(1, (i % 2) == 1, dv[i], 0, cyc);
    end
    step();
    m_rd_req = 0; s_rd_ready = 0;

    // read timeout, master 1
    m_addr[1] = 14'h3FFC; m_rd_req = 2'b10;
    n = cyc; s0 = srd_cnt;
    push(1, 1, 32'hDEAD_BEEF, 1, n + 64);
    repeat (64) step();
    @(negedge clk);
    chk("t4_busy_hi", busy, 1);
    chk("t4_saddr", s_addr, 14'h3FFC);
    step();
    m_rd_req = 0;
    @(negedge clk);
    chk("t4_busy_lo", busy, 0);
    chk("t4_one_srd", srd_cnt - s0, 1);

    // stalled write; master 1 read arrives meanwhile and waits
    step();
    m_addr[0] = 14'h0040; m_wr_data[0] = 32'hCAFE_F00D;
    m_wr_be[0] = 4'b0101; m_wr_req = 2'b01; s_wr_ready = 0; n = cyc;
    push(0, 0, '0, 0, n + 3);
    push(1, 1, 32'h5555_AAAA, 0, n + 5);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
      if (k == 1) begin
        m_addr[1] = 14'h0080; m_rd_req = 2'b10; s_rd_ready = 1;
      end
      if (k == 2) s_rd_ready = 0;
      if (k == 3) s_wr_ready = 1;
      @(negedge clk);
      chk("t5_swr", s_wr_req, 1);
      chk("t5_wdata", s_wr_data, 32'hCAFE_F00D);
      chk("t5_waddr", s_addr, 14'h0040);
      chk("t5_no_srd", s_rd_req, 0);
    end
    step();
    m_wr_req = 0; s_wr_ready = 0;
    @(negedge clk);
    chk("t5_m1_srd", s_rd_req, 1);
    chk("t5_m1_addr", s_addr, 14'h0080);
    step();
    s_rd_ready = 1; s_rd_data = 32'h5555_AAAA;
    step();
    m_rd_req = 0; s_rd_ready = 0;

    // reset during RD_WAIT drops the response
    m_addr[0] = 14'h0123; m_rd_req = 2'b01;
    step();
    rstb = 0; m_rd_req = 0;
    @(negedge clk);
    chk("t6_rst_outs", outs(), '0);
    step();
    rstb = 1; s_rd_ready = 1; s_rd_data = 32'h9999_9999;
    @(negedge clk);
    chk("t6_stray_outs", outs(), '0);
    step();
    s_rd_ready = 0;

    // slave ready on the timeout cycle: real data wins
    m_addr[0] = 14'h0444; m_rd_req = 2'b01; n = cyc;
    push(1, 0, 32'h7777_1234, 0, n + 64);
    repeat (64) step();
    s_rd_ready = 1; s_rd_data = 32'h7777_1234;
    @(negedge clk);
    chk("t7_err_lo", m_rd_err, 0);
    step();
    m_rd_req = 0; s_rd_ready = 0;
    @(negedge clk);
    chk("t7_idle", busy, 0);

    repeat (2) step();
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
